// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-owner arbiter for the shared memory port (I-cache, D-cache, DMA)
module mem_bus_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int READ_SIZE = 4 * WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ic_readM,
  input  logic [WORD_SIZE-1:0] ic_address,
  output logic                 ic_input_readyM,
  input  logic                 dc_readM,
  input  logic                 dc_writeM,
  input  logic [WORD_SIZE-1:0] dc_address,
  input  logic [READ_SIZE-1:0] dc_wdata,
  output logic                 dc_input_readyM,
  output logic                 dc_doneM,
  input  logic                 dma_br,
  output logic                 dma_bg,
  input  logic                 dma_writeM,
  input  logic [WORD_SIZE-1:0] dma_address,
  input  logic [READ_SIZE-1:0] dma_wdata,
  output logic                 dma_doneM,
  output logic                 bus_granted,
  output logic                 mem_readM,
  output logic                 mem_writeM,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [READ_SIZE-1:0] mem_wdata,
  input  logic [READ_SIZE-1:0] mem_rdata,
  output logic [READ_SIZE-1:0] rdata,
  input  logic                 mem_input_readyM,
  input  logic                 mem_doneM,
  output logic [WORD_SIZE-1:0] num_dma_grants,
  output logic [WORD_SIZE-1:0] num_conflict_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_IC, S_DC, S_DMA} state_t;

  state_t               r_state;
  logic                 r_last_dc;
  logic [WORD_SIZE-1:0] r_num_dma_grants;
  logic [WORD_SIZE-1:0] r_num_conflict_cycles;

  logic w_ic_req;
  logic w_dc_req;
  logic w_conflict;

  assign w_ic_req = ic_readM;
  assign w_dc_req = dc_readM | dc_writeM;

  always_comb begin
    w_conflict = 1'b0;
    case (r_state)
      S_IC:    w_conflict = w_dc_req | dma_br;
      S_DC:    w_conflict = w_ic_req | dma_br;
      S_DMA:   w_conflict = w_ic_req | w_dc_req;
      default: w_conflict = 1'b0;
    endcase
  end

  // r_last_dc starts at 0 (I-cache) so the D-cache wins the first tie
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state               <= S_IDLE;
      r_last_dc             <= 1'b0;
      r_num_dma_grants      <= '0;
      r_num_conflict_cycles <= '0;
    end else begin
      if (w_conflict) r_num_conflict_cycles <= r_num_conflict_cycles + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (dma_br) begin
            r_state          <= S_DMA;
            r_num_dma_grants <= r_num_dma_grants + 1'b1;
          end else if (w_ic_req && w_dc_req) begin
            r_state <= r_last_dc ? S_IC : S_DC;
          end else if (w_dc_req) begin
            r_state <= S_DC;
          end else if (w_ic_req) begin
            r_state <= S_IC;
          end
        end
        S_IC: begin
          if (!ic_readM) begin
            r_state <= S_IDLE;
          end else if (mem_input_readyM) begin
            r_state   <= S_IDLE;
            r_last_dc <= 1'b0;
          end
        end
        S_DC: begin
          if (dc_readM) begin
            if (mem_input_readyM) begin
              r_state   <= S_IDLE;
              r_last_dc <= 1'b1;
            end
          end else if (dc_writeM) begin
            if (mem_doneM) begin
              r_state   <= S_IDLE;
              r_last_dc <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DMA: begin
          if (!dma_br) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ic_input_readyM = 1'b0;
    dc_input_readyM = 1'b0;
    dc_doneM        = 1'b0;
    dma_bg          = 1'b0;
    dma_doneM       = 1'b0;
    bus_granted     = 1'b0;
    mem_readM       = 1'b0;
    mem_writeM      = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    case (r_state)
      S_IC: begin
        mem_readM       = ic_readM;
        mem_address     = ic_address;
        ic_input_readyM = mem_input_readyM;
      end
      S_DC: begin
        mem_readM       = dc_readM;
        mem_writeM      = dc_writeM & ~dc_readM;
        mem_address     = dc_address;
        mem_wdata       = dc_wdata;
        dc_input_readyM = mem_input_readyM;
        dc_doneM        = mem_doneM;
      end
      S_DMA: begin
        dma_bg      = 1'b1;
        bus_granted = 1'b1;
        mem_writeM  = dma_writeM;
        mem_address = dma_address;
        mem_wdata   = dma_wdata;
        dma_doneM   = mem_doneM;
      end
      default: ;
    endcase
  end

  assign rdata               = mem_rdata;
  assign num_dma_grants      = r_num_dma_grants;
  assign num_conflict_cycles = r_num_conflict_cycles;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Single-owner arbiter and sequencer for the one memory port shared by the instruction cache, the data cache and the DMA controller. It grants the port to one requester at a time at transaction boundaries and routes the memory handshake (input_readyM / doneM) back to the owner only. It drives the caches' bus_granted input and runs the BR/BG handshake with DMA. Sits between the two cache instances and the memory model in the top-level CPU.

Parameters:
WORD_SIZE, 16, address/word width
READ_SIZE, 4*WORD_SIZE, memory block width (one cache line)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
ic_readM  in  1  I-cache block read request
ic_address  in  WORD_SIZE  I-cache address
ic_input_readyM  out  1  read data valid, I-cache owner only
dc_readM  in  1  D-cache block read request
dc_writeM  in  1  D-cache block write request
dc_address  in  WORD_SIZE  D-cache address
dc_wdata  in  READ_SIZE  D-cache write data
dc_input_readyM  out  1  read data valid, D-cache owner only
dc_doneM  out  1  write complete, D-cache owner only
dma_br  in  1  DMA bus request
dma_bg  out  1  DMA bus grant
dma_writeM  in  1  DMA block write
dma_address  in  WORD_SIZE  DMA address
dma_wdata  in  READ_SIZE  DMA write data
dma_doneM  out  1  write complete, DMA owner only
bus_granted  out  1  to both caches; high while DMA owns the port
mem_readM / mem_writeM  out  1 each  to memory
mem_address  out  WORD_SIZE  to memory
mem_wdata  out  READ_SIZE  to memory
mem_rdata  in  READ_SIZE  from memory
rdata  out  READ_SIZE  mem_rdata passthrough to both caches
mem_input_readyM / mem_doneM  in  1 each  from memory
num_dma_grants  out  WORD_SIZE  count of DMA grants
num_conflict_cycles  out  WORD_SIZE  cycles a valid request waited while another owner held the port

Behaviour:
- FSM states: IDLE, IC, DC, DMA. Registered state; all routing is combinational from state.
- Reset: state=IDLE, last_cache=IC (so DC wins the first tie), both counters 0. All outputs low, mem_address/mem_wdata 0.
- IDLE decision, priority order: dma_br -> DMA; else IC and DC both requesting -> the cache not equal to last_cache; else whichever cache requests. The owner is entered on the next edge; 1-cycle arbitration latency. IDLE drives no memory request.
- IC: mem_readM=ic_readM, mem_address=ic_address. ic_input_readyM=mem_input_readyM.
- DC: mem_readM=dc_readM, mem_writeM=dc_writeM&!dc_readM (read wins if both are high), mem_address=dc_address, mem_wdata=dc_wdata. dc_input_readyM and dc_doneM forwarded from memory.
- Cache owner completion: read with mem_input_readyM=1, or write with mem_doneM=1 -> IDLE; last_cache<=owner. Mandatory 1-cycle IDLE bubble between owners, including same-owner back-to-back.
- Abort: owner deasserts all its requests before completion -> IDLE next edge; last_cache unchanged.
- DMA: dma_bg=1, bus_granted=1; mem_writeM=dma_writeM, mem_address=dma_address, mem_wdata=dma_wdata, dma_doneM forwarded. Held while dma_br=1. dma_br=0 -> IDLE. num_dma_grants increments on the IDLE->DMA edge.
- dma_br asserted mid cache transaction: no preemption. The current transaction completes, then the IDLE cycle grants DMA.
- Non-owner handshake outputs are always 0, even while memory pulses.
- num_conflict_cycles: +1 per cycle in IC/DC/DMA where a requester other than the owner asserts a request (max +1/cycle). Both counters wrap at 2^WORD_SIZE.
- Reset mid-transaction: returns to IDLE at the edge and all memory requests drop the same cycle. Memory must tolerate the abandoned request.

Test Plan:
- IC read only, memory input_readyM 3 cycles after grant -> mem_readM high cycles 1-3, ic_input_readyM pulses once, dc_input_readyM stays 0, then IDLE.
- IC and DC request together from reset -> DC is served first, then IDLE bubble, then IC. Each conflict cycle adds 1 to num_conflict_cycles.
- DC write in progress, dma_br raised mid-write -> write completes on mem_doneM; dma_bg and bus_granted are 1 from the cycle after the bubble; num_dma_grants=1.
- DMA holds the bus 5 cycles with two writes -> dma_doneM forwarded, caches see bus_granted=1. dma_br=0 returns to IDLE and a pending DC read is granted next.
- DC drops dc_readM before input_readyM -> IDLE next cycle, last_cache unchanged. IC+DC tie then goes to DC again.
- reset_n low while in DC -> all outputs 0 and state IDLE after the edge; counters 0.
